// File: rtl/popcount_serial_pkg.sv
// popcount_serial_pkg
// Shared definitions for the serial popcount block: the FSM state
// encoding and the counting-mode encoding seen on mode_i.
// No ports; imported by popcount_serial.

package popcount_serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // mode_i encoding: count the ones as presented, or count the zeros
  localparam logic MODE_ONES  = 1'b0;
  localparam logic MODE_ZEROS = 1'b1;

endpackage

// File: rtl/popcount_serial_pair_count.sv
// pair_count
// Counts the ones in a 2-bit slice. The result is 0, 1 or 2.
// Ports:
//   bits  in   2  slice to count
//   ones  out  2  number of set bits in the slice

module pair_count (
  input  logic [1:0] bits,
  output logic [1:0] ones
);

  // Half adder: carry gives the 2, sum gives the 1
  assign ones = {bits[1] & bits[0], bits[1] ^ bits[0]};

endmodule

// File: rtl/popcount_serial.sv
// popcount_serial
// Serial population counter. One word is accepted in IDLE, then counted
// two bits per cycle in COUNT, and the result is presented in DONE until
// the consumer takes it. Zero counting is done by inverting the word at
// accept time, so the datapath only ever counts ones.
// WIDTH must be even and at least 2.
// Ports:
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      data_i/mode_i carry a word
//   in_ready   out  1      block is idle and can take a word
//   data_i     in   WIDTH  word to count
//   mode_i     in   1      0 = count ones, 1 = count zeros
//   out_valid  out  1      count_o holds a result
//   out_ready  in   1      consumer takes the result
//   count_o    out  CNT_W  result, 0 outside DONE
//   busy_o     out  1      high in COUNT and DONE

module popcount_serial
  import popcount_serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_i,
  input  logic             mode_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count_o,
  output logic             busy_o
);

  localparam int PAIRS  = WIDTH / 2;
  localparam int PAIR_W = $clog2(PAIRS + 1);

  state_t             state;
  logic [WIDTH-1:0]   shift_q;
  logic [CNT_W-1:0]   acc_q;
  logic [PAIR_W-1:0]  pair_q;
  logic [1:0]         pair_ones;
  logic [CNT_W-1:0]   acc_next;

  pair_count u_pair_count (
    .bits (shift_q[1:0]),
    .ones (pair_ones)
  );

  // Running total including the pair currently at the bottom of the
  // shift register; the final value of this is the result.
  assign acc_next = acc_q + CNT_W'(pair_ones);

  // Control flags and count_o are registered alongside the state so they
  // change only with the state and come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      shift_q   <= '0;
      acc_q     <= '0;
      pair_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy_o    <= 1'b0;
      count_o   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            shift_q  <= (mode_i == MODE_ZEROS) ? ~data_i : data_i;
            acc_q    <= '0;
            pair_q   <= '0;
            state    <= ST_COUNT;
            in_ready <= 1'b0;
            busy_o   <= 1'b1;
          end
        end
        ST_COUNT: begin
          acc_q   <= acc_next;
          shift_q <= shift_q >> 2;
          pair_q  <= pair_q + PAIR_W'(1);
          // Last pair: hand the completed total straight to count_o
          if (pair_q == PAIR_W'(PAIRS - 1)) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            count_o   <= acc_next;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy_o    <= 1'b0;
            count_o   <= '0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy_o    <= 1'b0;
          count_o   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_popcount_serial.sv
// tb_popcount_serial
// Directed checks on an 8-bit instance followed by randomized words run
// through 2-, 8- and 16-bit instances in lockstep, compared against a
// plain bit-counting reference.

module tb_popcount_serial;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        mode;
  logic        out_ready;
  logic [15:0] data;

  logic        in_ready2, out_valid2, busy2;
  logic [1:0]  count2;
  logic        in_ready8, out_valid8, busy8;
  logic [3:0]  count8;
  logic        in_ready16, out_valid16, busy16;
  logic [4:0]  count16;

  int checks = 0;
  int errors = 0;

  popcount_serial #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .data_i(data[1:0]), .mode_i(mode), .out_valid(out_valid2),
    .out_ready(out_ready), .count_o(count2), .busy_o(busy2)
  );

  popcount_serial #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
    .data_i(data[7:0]), .mode_i(mode), .out_valid(out_valid8),
    .out_ready(out_ready), .count_o(count8), .busy_o(busy8)
  );

  popcount_serial #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
    .data_i(data), .mode_i(mode), .out_valid(out_valid16),
    .out_ready(out_ready), .count_o(count16), .busy_o(busy16)
  );

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  // Reference: count the ones in the low w bits, then flip for zero mode
  function automatic int ref_count(input logic [15:0] d, input int w, input logic m);
    int ones;
    ones = 0;
    for (int i = 0; i < w; i++) ones += int'(d[i]);
    return m ? (w - ones) : ones;
  endfunction

  // Advance one edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one word for a single accept edge, then scramble the bus so
  // any late sampling of data_i/mode_i would corrupt the result
  task automatic apply_stimulus(input logic [15:0] d, input logic m, input logic rdy);
    data      = d;
    mode      = m;
    out_ready = rdy;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    data     = 16'($urandom);
    mode     = 1'($urandom_range(0, 1));
  endtask

  // Edges from the accept edge (counted as 1) until dut8 shows out_valid
  task automatic wait8(output int edges);
    edges = 1;
    while (!out_valid8 && edges < 40) begin
      tick();
      edges++;
    end
  endtask

  task automatic run8(input string tag, input logic [7:0] d, input logic m, input int exp);
    int edges;
    check_output({tag, "_ready_before"}, 32'(in_ready8), 1);
    apply_stimulus({8'h00, d}, m, 1'b1);
    check_output({tag, "_busy"}, 32'(busy8), 1);
    check_output({tag, "_count_while_busy"}, 32'(count8), 0);
    wait8(edges);
    check_output({tag, "_latency"}, 32'(edges), 5);
    check_output({tag, "_count"}, 32'(count8), 32'(exp));
    tick();
    check_output({tag, "_ready_after"}, 32'(in_ready8), 1);
    check_output({tag, "_count_after"}, 32'(count8), 0);
  endtask

  initial begin
    int          edges;
    logic [15:0] d;
    logic        m;

    clk       = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    mode      = 1'b0;
    out_ready = 1'b1;
    data      = '0;

    #12;
    check_output("rst_in_ready", 32'(in_ready8), 1);
    check_output("rst_out_valid", 32'(out_valid8), 0);
    check_output("rst_busy", 32'(busy8), 0);
    check_output("rst_count", 32'(count8), 0);

    // Release mid-cycle; the very next edge must accept the word
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run8("ff_ones", 8'hFF, 1'b0, 8);
    run8("00_ones", 8'h00, 1'b0, 0);
    run8("00_zeros", 8'h00, 1'b1, 8);
    run8("a5_zeros", 8'hA5, 1'b1, 4);
    run8("81_ones", 8'h81, 1'b0, 2);

    // Result held with out_ready low while new words are offered
    apply_stimulus(16'h00FF, 1'b0, 1'b0);
    wait8(edges);
    check_output("hold_latency", 32'(edges), 5);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      data     = 16'h0000;
      mode     = 1'b0;
      tick();
      check_output("hold_valid", 32'(out_valid8), 1);
      check_output("hold_count", 32'(count8), 8);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check_output("hold_release_ready", 32'(in_ready8), 1);
    check_output("hold_release_valid", 32'(out_valid8), 0);
    tick();
    check_output("hold_no_reaccept", 32'(busy8), 0);

    // Asynchronous reset two cycles into COUNT
    apply_stimulus(16'h00FF, 1'b0, 1'b1);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_output("midrst_in_ready", 32'(in_ready8), 1);
    check_output("midrst_out_valid", 32'(out_valid8), 0);
    check_output("midrst_busy", 32'(busy8), 0);
    check_output("midrst_count", 32'(count8), 0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_output("midrst_no_result", 32'(out_valid8), 0);
    end
    run8("0f_after_rst", 8'h0F, 1'b0, 4);

    // Randomized words through all three widths together
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
    for (int n = 0; n < 1000; n++) begin
      d = 16'($urandom);
      m = 1'($urandom_range(0, 1));
      check_output("rand_all_ready", 32'({in_ready2, in_ready8, in_ready16}), 32'h7);
      apply_stimulus(d, m, 1'b0);
      edges = 1;
      while (!(out_valid2 && out_valid8 && out_valid16) && edges < 30) begin
        tick();
        edges++;
      end
      check_output("rand_all_valid", 32'({out_valid2, out_valid8, out_valid16}), 32'h7);
      check_output("rand_w2", 32'(count2), 32'(ref_count(d, 2, m)));
      check_output("rand_w8", 32'(count8), 32'(ref_count(d, 8, m)));
      check_output("rand_w16", 32'(count16), 32'(ref_count(d, 16, m)));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
